// File: rtl/ppu_ctrl_pipeline.sv
// ppu_ctrl_pipeline: carries the decoded PPU control word through the ID/EX,
// EX/MEM and MEM/WB stage registers, resolves the destination register,
// inserts bubbles on stall/flush and flags load-use hazards against ID.
module ppu_ctrl_pipeline (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] id_ctrl,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        flush,
    input  logic        ext_stall,
    output logic        load_use_stall,
    output logic        ex_valid,
    output logic        ex_b_instr,
    output logic        ex_ta_instr,
    output logic        ex_uncond_jump,
    output logic        ex_cond_uncond_jump,
    output logic        ex_mux_rs_addr,
    output logic        ex_addr_mux,
    output logic [3:0]  ex_alu_op,
    output logic [2:0]  ex_src_op,
    output logic        ex_rf_we,
    output logic [4:0]  ex_dest,
    output logic        mem_valid,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic        mem_se,
    output logic        mem_load,
    output logic        mem_rf_we,
    output logic [1:0]  mem_size,
    output logic [4:0]  mem_dest,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic        wb_load,
    output logic        wb_hi_we,
    output logic        wb_lo_we,
    output logic [4:0]  wb_dest
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned SIZE_W = 2;
    localparam logic [REG_W-1:0] LINK_REG = REG_W'(31);

    // Destination_Register selector encodings
    localparam logic [1:0] DSEL_NONE = 2'b00;
    localparam logic [1:0] DSEL_RD   = 2'b01;
    localparam logic [1:0] DSEL_RT   = 2'b10;
    localparam logic [1:0] DSEL_LINK = 2'b11;

    typedef struct packed {
        logic              valid;
        logic              b_instr;
        logic              ta_instr;
        logic              uncond_jump;
        logic              cond_uncond_jump;
        logic              mux_rs_addr;
        logic              addr_mux;
        logic [ALU_W-1:0]  alu_op;
        logic [SRC_W-1:0]  src_op;
        logic              rf_we;
        logic [REG_W-1:0]  dest;
        logic              load;
        logic              mem_enable;
        logic              mem_rw;
        logic              mem_se;
        logic [SIZE_W-1:0] mem_size;
        logic              hi_we;
        logic              lo_we;
    } ex_stage_t;

    typedef struct packed {
        logic              valid;
        logic              mem_enable;
        logic              mem_rw;
        logic              mem_se;
        logic [SIZE_W-1:0] mem_size;
        logic              load;
        logic              rf_we;
        logic [REG_W-1:0]  dest;
        logic              hi_we;
        logic              lo_we;
    } mem_stage_t;

    typedef struct packed {
        logic              valid;
        logic              rf_we;
        logic              load;
        logic              hi_we;
        logic              lo_we;
        logic [REG_W-1:0]  dest;
    } wb_stage_t;

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q,  wb_d;

    logic [1:0]       dest_sel;
    logic [REG_W-1:0] id_dest;
    logic             id_rf_we;
    logic             id_load;
    logic             hazard;
    logic             insert_bubble;

    // Resolve the destination register and the derived write/load enables for ID
    always_comb begin
        dest_sel = id_ctrl[19:18];
        id_dest  = '0;
        case (dest_sel)
            DSEL_NONE: id_dest = '0;
            DSEL_RD:   id_dest = id_rd;
            DSEL_RT:   id_dest = id_rt;
            DSEL_LINK: id_dest = LINK_REG;
            default:   id_dest = '0;
        endcase
        // r0 is hardwired, so a write to it is dropped at the source
        id_rf_we = id_ctrl[8] & (dest_sel != DSEL_NONE) & (id_dest != '0);
        // Load_Instr alone also marks immediate ALU ops; only a memory access is a load
        id_load  = id_ctrl[9] & id_ctrl[2];
    end

    // Load-use hazard: the load in EX writes a register the ID instruction reads
    always_comb begin
        hazard = ex_q.valid & ex_q.load & ex_q.rf_we &
                 ((ex_q.dest == id_rs) | (ex_q.dest == id_rt));
        insert_bubble = hazard | ext_stall | flush;
    end

    assign load_use_stall = hazard;

    // ID/EX capture: unpack the control word, or load a bubble on stall/flush
    always_comb begin
        ex_d = '0;
        if (!insert_bubble) begin
            ex_d.valid            = 1'b1;
            ex_d.lo_we            = id_ctrl[0];
            ex_d.hi_we            = id_ctrl[1];
            ex_d.mem_enable       = id_ctrl[2];
            ex_d.mem_se           = id_ctrl[3];
            ex_d.mem_rw           = id_ctrl[4];
            ex_d.mem_size         = id_ctrl[6:5];
            ex_d.ta_instr         = id_ctrl[7];
            ex_d.b_instr          = id_ctrl[10];
            ex_d.alu_op           = id_ctrl[14:11];
            ex_d.src_op           = id_ctrl[17:15];
            ex_d.uncond_jump      = id_ctrl[20];
            ex_d.cond_uncond_jump = id_ctrl[21];
            ex_d.mux_rs_addr      = id_ctrl[22];
            ex_d.addr_mux         = id_ctrl[23];
            ex_d.rf_we            = id_rf_we;
            ex_d.dest             = id_dest;
            ex_d.load             = id_load;
        end
    end

    // EX/MEM advance every cycle; an invalid EX slot becomes an all-zero bubble
    always_comb begin
        mem_d = '0;
        if (ex_q.valid) begin
            mem_d.valid      = 1'b1;
            mem_d.mem_enable = ex_q.mem_enable;
            mem_d.mem_rw     = ex_q.mem_rw;
            mem_d.mem_se     = ex_q.mem_se;
            mem_d.mem_size   = ex_q.mem_size;
            mem_d.load       = ex_q.load;
            mem_d.rf_we      = ex_q.rf_we;
            mem_d.dest       = ex_q.dest;
            mem_d.hi_we      = ex_q.hi_we;
            mem_d.lo_we      = ex_q.lo_we;
        end
    end

    // MEM/WB advance every cycle; no downstream backpressure exists
    always_comb begin
        wb_d = '0;
        if (mem_q.valid) begin
            wb_d.valid = 1'b1;
            wb_d.rf_we = mem_q.rf_we;
            wb_d.load  = mem_q.load;
            wb_d.hi_we = mem_q.hi_we;
            wb_d.lo_we = mem_q.lo_we;
            wb_d.dest  = mem_q.dest;
        end
    end

    // Stage registers; reset discards every in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // EX outputs
    assign ex_valid            = ex_q.valid;
    assign ex_b_instr          = ex_q.b_instr;
    assign ex_ta_instr         = ex_q.ta_instr;
    assign ex_uncond_jump      = ex_q.uncond_jump;
    assign ex_cond_uncond_jump = ex_q.cond_uncond_jump;
    assign ex_mux_rs_addr      = ex_q.mux_rs_addr;
    assign ex_addr_mux         = ex_q.addr_mux;
    assign ex_alu_op           = ex_q.alu_op;
    assign ex_src_op           = ex_q.src_op;
    assign ex_rf_we            = ex_q.rf_we;
    assign ex_dest             = ex_q.dest;

    // MEM outputs
    assign mem_valid  = mem_q.valid;
    assign mem_enable = mem_q.mem_enable;
    assign mem_rw     = mem_q.mem_rw;
    assign mem_se     = mem_q.mem_se;
    assign mem_load   = mem_q.load;
    assign mem_rf_we  = mem_q.rf_we;
    assign mem_size   = mem_q.mem_size;
    assign mem_dest   = mem_q.dest;

    // WB outputs
    assign wb_valid = wb_q.valid;
    assign wb_rf_we = wb_q.rf_we;
    assign wb_load  = wb_q.load;
    assign wb_hi_we = wb_q.hi_we;
    assign wb_lo_we = wb_q.lo_we;
    assign wb_dest  = wb_q.dest;

endmodule

// File: tb/tb_ppu_ctrl_pipeline.sv
// Scoreboard bench for ppu_ctrl_pipeline: stimulus pushes per-stage expected
// records from an instruction-level model; a monitor pops and compares.
module tb_ppu_ctrl_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush, ext_stall;
    logic        load_use_stall;
    logic        ex_valid, ex_b_instr, ex_ta_instr, ex_uncond_jump, ex_cond_uncond_jump;
    logic        ex_mux_rs_addr, ex_addr_mux, ex_rf_we;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_src_op;
    logic [4:0]  ex_dest;
    logic        mem_valid, mem_enable, mem_rw, mem_se, mem_load, mem_rf_we;
    logic [1:0]  mem_size;
    logic [4:0]  mem_dest;
    logic        wb_valid, wb_rf_we, wb_load, wb_hi_we, wb_lo_we;
    logic [4:0]  wb_dest;

    ppu_ctrl_pipeline dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .ext_stall(ext_stall), .load_use_stall(load_use_stall),
        .ex_valid(ex_valid), .ex_b_instr(ex_b_instr), .ex_ta_instr(ex_ta_instr),
        .ex_uncond_jump(ex_uncond_jump), .ex_cond_uncond_jump(ex_cond_uncond_jump),
        .ex_mux_rs_addr(ex_mux_rs_addr), .ex_addr_mux(ex_addr_mux),
        .ex_alu_op(ex_alu_op), .ex_src_op(ex_src_op), .ex_rf_we(ex_rf_we), .ex_dest(ex_dest),
        .mem_valid(mem_valid), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_se(mem_se),
        .mem_load(mem_load), .mem_rf_we(mem_rf_we), .mem_size(mem_size), .mem_dest(mem_dest),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_load(wb_load),
        .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we), .wb_dest(wb_dest)
    );

    always #5 clk = ~clk;

    // Instruction attributes as the pipeline should present them
    typedef struct packed {
        logic       valid;
        logic       b_instr, ta_instr, uj, cuj, mux_rs, addr_mux;
        logic [3:0] alu;
        logic [2:0] src;
        logic       rf_we;
        logic [4:0] dest;
        logic       load, mem_en, mem_rw, mem_se;
        logic [1:0] mem_size;
        logic       hi_we, lo_we;
    } rec_t;

    typedef struct {
        int   due;
        rec_t r;
    } ent_t;

    ent_t ex_sb[$];
    ent_t mem_sb[$];
    ent_t wb_sb[$];
    bit   stall_sb[$];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    rec_t prev_ex = '0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [23:0] ADDIU = 24'h0A0300;
    localparam logic [23:0] LBU   = 24'h0A032C;
    localparam logic [23:0] SUBU  = 24'h040900;
    localparam logic [23:0] JAL   = 24'h3DE100;

    // Reference: what an instruction means, independent of pipeline staging
    function automatic rec_t model(input logic [23:0] c, input logic [4:0] rt, input logic [4:0] rd);
        rec_t r;
        int   d;
        r = '0;
        case (int'(c[19:18]))
            0: d = 0;
            1: d = int'(rd);
            2: d = int'(rt);
            default: d = 31;
        endcase
        r.valid    = 1'b1;
        r.lo_we    = c[0];
        r.hi_we    = c[1];
        r.mem_en   = c[2];
        r.mem_se   = c[3];
        r.mem_rw   = c[4];
        r.mem_size = c[6:5];
        r.ta_instr = c[7];
        r.b_instr  = c[10];
        r.alu      = c[14:11];
        r.src      = c[17:15];
        r.uj       = c[20];
        r.cuj      = c[21];
        r.mux_rs   = c[22];
        r.addr_mux = c[23];
        r.dest     = 5'(d);
        r.rf_we    = c[8] && (c[19:18] != 2'b00) && (d != 0);
        r.load     = c[9] && c[2];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ent_t mk(input int due, input rec_t r);
        ent_t e;
        e.due = due;
        e.r   = r;
        return e;
    endfunction

    // Drive one cycle of ID inputs and record what each stage must show
    task automatic step(input bit rst, input logic [23:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input bit fl, input bit es);
        rec_t r;
        bit   st;
        int   due;
        @(negedge clk);
        reset = rst; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        flush = fl; ext_stall = es;
        st = prev_ex.valid && prev_ex.load && prev_ex.rf_we &&
             ((prev_ex.dest == rs) || (prev_ex.dest == rt));
        stall_sb.push_back(st);
        due = cyc + 1;
        if (rst) begin
            while (ex_sb.size()  > 0 && ex_sb[$].due  >= due) void'(ex_sb.pop_back());
            while (mem_sb.size() > 0 && mem_sb[$].due >= due) void'(mem_sb.pop_back());
            while (wb_sb.size()  > 0 && wb_sb[$].due  >= due) void'(wb_sb.pop_back());
            ex_sb.push_back(mk(due, '0));
            mem_sb.push_back(mk(due, '0));
            mem_sb.push_back(mk(due + 1, '0));
            wb_sb.push_back(mk(due, '0));
            wb_sb.push_back(mk(due + 1, '0));
            wb_sb.push_back(mk(due + 2, '0));
            prev_ex = '0;
        end else begin
            r = (st || fl || es) ? rec_t'('0) : model(c, rt, rd);
            ex_sb.push_back(mk(due, r));
            mem_sb.push_back(mk(due + 1, r));
            wb_sb.push_back(mk(due + 2, r));
            prev_ex = r;
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Monitor: compare stage outputs after each edge, hazard flag mid-cycle
    initial begin
        ent_t       e;
        logic [19:0] ea, ee;
        logic [12:0] ma, me;
        logic [9:0]  wa, we;
        bit          st;
        forever begin
            @(posedge clk);
            #1;
            while (ex_sb.size() > 0 && ex_sb[0].due < cyc) begin
                void'(ex_sb.pop_front()); checks++; errors++;
                $display("FAIL ex_stale: got none expected entry (cycle %0d)", cyc);
            end
            if (ex_sb.size() > 0 && ex_sb[0].due == cyc) begin
                e  = ex_sb.pop_front();
                ea = {ex_valid, ex_b_instr, ex_ta_instr, ex_uncond_jump, ex_cond_uncond_jump,
                      ex_mux_rs_addr, ex_addr_mux, ex_alu_op, ex_src_op, ex_rf_we, ex_dest};
                ee = {e.r.valid, e.r.b_instr, e.r.ta_instr, e.r.uj, e.r.cuj, e.r.mux_rs,
                      e.r.addr_mux, e.r.alu, e.r.src, e.r.rf_we, e.r.dest};
                checks++;
                if (ea !== ee) begin
                    errors++;
                    $display("FAIL ex_stage: got %h expected %h (cycle %0d)", ea, ee, cyc);
                end
            end
            if (mem_sb.size() > 0 && mem_sb[0].due == cyc) begin
                e  = mem_sb.pop_front();
                ma = {mem_valid, mem_enable, mem_rw, mem_se, mem_load, mem_rf_we, mem_size, mem_dest};
                me = {e.r.valid, e.r.mem_en, e.r.mem_rw, e.r.mem_se, e.r.load, e.r.rf_we,
                      e.r.mem_size, e.r.dest};
                checks++;
                if (ma !== me) begin
                    errors++;
                    $display("FAIL mem_stage: got %h expected %h (cycle %0d)", ma, me, cyc);
                end
            end
            if (wb_sb.size() > 0 && wb_sb[0].due == cyc) begin
                e  = wb_sb.pop_front();
                wa = {wb_valid, wb_rf_we, wb_load, wb_hi_we, wb_lo_we, wb_dest};
                we = {e.r.valid, e.r.rf_we, e.r.load, e.r.hi_we, e.r.lo_we, e.r.dest};
                checks++;
                if (wa !== we) begin
                    errors++;
                    $display("FAIL wb_stage: got %h expected %h (cycle %0d)", wa, we, cyc);
                end
            end
            @(negedge clk);
            #1;
            if (stall_sb.size() > 0) begin
                st = stall_sb.pop_front();
                checks++;
                if (load_use_stall !== st) begin
                    errors++;
                    $display("FAIL load_use_stall: got %b expected %b (cycle %0d)",
                             load_use_stall, st, cyc);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        logic [23:0] tbl [4];
        logic [23:0] c;
        tbl[0] = ADDIU; tbl[1] = LBU; tbl[2] = SUBU; tbl[3] = JAL;
        reset = 1'b1; id_ctrl = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        flush = 1'b0; ext_stall = 1'b0;

        step(1'b1, 24'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 24'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // ADDIU into rt=5
        step(1'b0, ADDIU, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("addiu_ex_rf_we", int'(ex_rf_we), 1);
        chk("addiu_ex_dest", int'(ex_dest), 5);
        chk("addiu_ex_src_op", int'(ex_src_op), 4);
        nop(3);

        // LBU r8 followed by dependent SUBU r9 <- r8
        step(1'b0, LBU, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
        step(1'b0, SUBU, 5'd8, 5'd0, 5'd9, 1'b0, 1'b0);
        #1 chk("lbu_subu_stall", int'(load_use_stall), 1);
        step(1'b0, SUBU, 5'd8, 5'd0, 5'd9, 1'b0, 1'b0);
        #1 chk("lbu_subu_stall_drop", int'(load_use_stall), 0);
        @(posedge clk); #2;
        chk("subu_ex_dest", int'(ex_dest), 9);
        chk("subu_ex_alu_op", int'(ex_alu_op), 1);
        nop(3);

        // JAL links r31
        step(1'b0, JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("jal_ex_dest", int'(ex_dest), 31);
        chk("jal_ex_alu_op", int'(ex_alu_op), 12);
        nop(3);

        // SUBU writing r0 must not enable a write
        step(1'b0, SUBU, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        nop(3);

        // flush together with ext_stall while ADDIU is in ID
        step(1'b0, JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b0, ADDIU, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #2;
        chk("flush_stall_ex_valid", int'(ex_valid), 0);
        nop(3);

        // Reset with three valid instructions in flight
        step(1'b0, ADDIU, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        step(1'b0, SUBU, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
        step(1'b0, JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, ADDIU, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        nop(4);

        // Randomized traffic with frequent register overlap
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) c = tbl[$urandom_range(0, 3)];
            else c = 24'($urandom());
            step($urandom_range(0, 49) == 0, c,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        nop(4);

        repeat (4) @(posedge clk);
        #3;
        chk("scoreboard_drained", ex_sb.size() + mem_sb.size() + wb_sb.size() + stall_sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
